mic1_run_ctrl: RTL and testbench

- Run/step controller for the Mic-1 core.
- Consumes single-cycle debounced button events from the button front end.
- Drives the core clock enable: free run at full or divided speed, single microinstruction step, or macro step (run until next-address returns to Main1).
- Reports its state on board LEDs and counts issued core cycles.

---
 rtl/mic1_run_ctrl_if.sv | 27 ++
 rtl/mic1_run_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mic1_run_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mic1_run_ctrl_if.sv
// Button-event, core-handshake and status bundle between the Mic-1 board front end
// and the run/step controller.
interface mic1_run_ctrl_if #(
    parameter int unsigned MPC_W = 9
);
    logic             start_stop_evt;
    logic             step_evt;
    logic             mode_evt;
    logic             speed_evt;
    logic             core_halt;
    logic [MPC_W-1:0] mpc_next;
    logic             core_ce;
    logic [3:0]       led_run;
    logic             led_step_mode;
    logic             led_speed;
    logic [31:0]      cycle_cnt;

    modport master (
        output start_stop_evt, step_evt, mode_evt, speed_evt, core_halt, mpc_next,
        input  core_ce, led_run, led_step_mode, led_speed, cycle_cnt
    );

    modport slave (
        input  start_stop_evt, step_evt, mode_evt, speed_evt, core_halt, mpc_next,
        output core_ce, led_run, led_step_mode, led_speed, cycle_cnt
    );
endinterface

// File: rtl/mic1_run_ctrl.sv
// Run/step controller for the Mic-1 core: gates the core clock enable for free run,
// micro step and macro step. Define CYCLE_COUNTER_EN to build the 32-bit core cycle counter.
module mic1_run_ctrl #(
    parameter int unsigned      SLOW_DIV   = 12_500_000,
    parameter int unsigned      MPC_W      = 9,
    parameter logic [MPC_W-1:0] MAIN1_ADDR = 9'h000
) (
    input  logic           clk,
    input  logic           reset,
    mic1_run_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP_U = 3'd2,
        ST_STEP_M = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    localparam logic [23:0] PRESC_LAST = 24'(SLOW_DIV - 1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [23:0] presc_r;
    logic [23:0] presc_nxt_s;
    logic        core_ce_r;
    logic        core_ce_nxt_s;
    logic        step_mode_r;
    logic        step_mode_nxt_s;
    logic        speed_r;
    logic        speed_nxt_s;
    logic [3:0]  led_run_r;

    function automatic logic is_active(input state_t st);
        is_active = (st == ST_RUN) || (st == ST_STEP_U) || (st == ST_STEP_M);
    endfunction

    function automatic logic [3:0] run_leds(input state_t st);
        case (st)
            ST_IDLE:   run_leds = 4'b0001;
            ST_RUN:    run_leds = 4'b0010;
            ST_STEP_U: run_leds = 4'b0100;
            ST_STEP_M: run_leds = 4'b0100;
            ST_HALTED: run_leds = 4'b1000;
            default:   run_leds = 4'b0001;
        endcase
    endfunction

    // Next-state, prescaler and clock-enable decode; events follow halt > start/stop > step > mode/speed.
    always_comb begin
        state_nxt_s     = state_r;
        step_mode_nxt_s = step_mode_r;
        speed_nxt_s     = speed_r;
        presc_nxt_s     = 24'd0;
        core_ce_nxt_s   = 1'b0;

        if (bus.core_halt) begin
            state_nxt_s = ST_HALTED;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start_stop_evt) begin
                        state_nxt_s = ST_RUN;
                    end else if (bus.step_evt) begin
                        state_nxt_s = step_mode_r ? ST_STEP_M : ST_STEP_U;
                    end else begin
                        step_mode_nxt_s = step_mode_r ^ bus.mode_evt;
                        speed_nxt_s     = speed_r ^ bus.speed_evt;
                    end
                end
                ST_RUN: begin
                    if (bus.start_stop_evt) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_STEP_U: begin
                    // The pulse currently on the core ends the micro step.
                    if (bus.start_stop_evt || core_ce_r) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_STEP_U;
                    end
                end
                ST_STEP_M: begin
                    if (bus.start_stop_evt || (core_ce_r && (bus.mpc_next == MAIN1_ADDR))) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_STEP_M;
                    end
                end
                ST_HALTED: begin
                    state_nxt_s = ST_HALTED;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end

        // Prescaler restarts from zero whenever an active state is entered.
        if (is_active(state_nxt_s) && is_active(state_r) && speed_r) begin
            presc_nxt_s = (presc_r == PRESC_LAST) ? 24'd0 : (presc_r + 24'd1);
        end else begin
            presc_nxt_s = 24'd0;
        end

        if (is_active(state_nxt_s)) begin
            core_ce_nxt_s = !speed_r || (presc_nxt_s == PRESC_LAST);
        end else begin
            core_ce_nxt_s = 1'b0;
        end
    end

    // State, prescaler and registered outputs; reset drops core_ce asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            presc_r     <= 24'd0;
            core_ce_r   <= 1'b0;
            step_mode_r <= 1'b0;
            speed_r     <= 1'b0;
            led_run_r   <= 4'b0001;
        end else begin
            state_r     <= state_nxt_s;
            presc_r     <= presc_nxt_s;
            core_ce_r   <= core_ce_nxt_s;
            step_mode_r <= step_mode_nxt_s;
            speed_r     <= speed_nxt_s;
            led_run_r   <= run_leds(state_nxt_s);
        end
    end

    assign bus.core_ce       = core_ce_r;
    assign bus.led_run       = led_run_r;
    assign bus.led_step_mode = step_mode_r;
    assign bus.led_speed     = speed_r;

`ifdef CYCLE_COUNTER_EN
    logic [31:0] cycle_cnt_r;

    // Counts every edge at which the core was enabled; wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt_r <= 32'd0;
        end else if (core_ce_r) begin
            cycle_cnt_r <= cycle_cnt_r + 32'd1;
        end else begin
            cycle_cnt_r <= cycle_cnt_r;
        end
    end

    assign bus.cycle_cnt = cycle_cnt_r;
`else
    assign bus.cycle_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mic1_run_ctrl.sv
// Scoreboard bench for mic1_run_ctrl: expected core_ce pulse cycles are queued by the
// stimulus and consumed by an independent negedge monitor.
module tb_mic1_run_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_total = 0;
    int   exp_q[$];

    mic1_run_ctrl_if #(.MPC_W(9)) bus ();

    mic1_run_ctrl #(
        .SLOW_DIV  (4),
        .MPC_W     (9),
        .MAIN1_ADDR(9'h000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: core_ce must be high exactly in the queued cycles.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0] == cyc) begin
            checks++;
            if (bus.core_ce !== 1'b1) begin
                errors++;
                $display("FAIL core_ce_pulse cycle %0d got %b want 1", cyc, bus.core_ce);
            end
            void'(exp_q.pop_front());
        end else begin
            checks++;
            if (bus.core_ce !== 1'b0) begin
                errors++;
                $display("FAIL core_ce_quiet cycle %0d got %b want 0", cyc, bus.core_ce);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h want %0h", name, cyc, got, want);
        end
    endtask

    function automatic logic [31:0] want_cnt();
`ifdef CYCLE_COUNTER_EN
        return 32'(exp_total);
`else
        return 32'd0;
`endif
    endfunction

    task automatic expect_ce(input int c);
        exp_q.push_back(c);
        exp_total++;
    endtask

    // Called at a negedge: holds one event for one cycle, returns at the next negedge.
    task automatic pulse_evt(input int which);
        case (which)
            0:       bus.start_stop_evt = 1'b1;
            1:       bus.step_evt       = 1'b1;
            2:       bus.mode_evt       = 1'b1;
            default: bus.speed_evt      = 1'b1;
        endcase
        @(negedge clk);
        bus.start_stop_evt = 1'b0;
        bus.step_evt       = 1'b0;
        bus.mode_evt       = 1'b0;
        bus.speed_evt      = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset     = 1'b0;
        exp_total = 0;
        @(negedge clk);
    endtask

    initial begin
        reset              = 1'b1;
        bus.start_stop_evt = 1'b0;
        bus.step_evt       = 1'b0;
        bus.mode_evt       = 1'b0;
        bus.speed_evt      = 1'b0;
        bus.core_halt      = 1'b0;
        bus.mpc_next       = 9'h1FF;
        repeat (3) @(negedge clk);
        chk("rst_core_ce", {31'd0, bus.core_ce}, 32'd0);
        chk("rst_led_run", {28'd0, bus.led_run}, 32'h1);
        chk("rst_step_mode", {31'd0, bus.led_step_mode}, 32'd0);
        chk("rst_speed", {31'd0, bus.led_speed}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cycle_cnt", bus.cycle_cnt, 32'd0);

        // Full-speed run: ten pulses between start and stop.
        for (int k = 1; k <= 10; k++) expect_ce(cyc + k);
        pulse_evt(0);
        chk("run_led", {28'd0, bus.led_run}, 32'h2);
        repeat (9) @(negedge clk);
        pulse_evt(0);
        chk("run_stop_led", {28'd0, bus.led_run}, 32'h1);
        chk("run_cycle_cnt", bus.cycle_cnt, want_cnt());

        // Slow run: pulses in cycles 4, 8, 12 after entry; step ignored while running.
        pulse_evt(3);
        chk("slow_led_speed", {31'd0, bus.led_speed}, 32'd1);
        expect_ce(cyc + 4);
        expect_ce(cyc + 8);
        expect_ce(cyc + 12);
        pulse_evt(0);
        repeat (5) @(negedge clk);
        pulse_evt(1);
        repeat (5) @(negedge clk);
        chk("slow_run_led", {28'd0, bus.led_run}, 32'h2);
        pulse_evt(0);
        chk("slow_stop_led", {28'd0, bus.led_run}, 32'h1);
        pulse_evt(3);
        chk("fast_led_speed", {31'd0, bus.led_speed}, 32'd0);

        // Micro steps, spaced five cycles apart.
        for (int s = 0; s < 3; s++) begin
            expect_ce(cyc + 1);
            pulse_evt(1);
            chk("ustep_led", {28'd0, bus.led_run}, 32'h4);
            repeat (4) @(negedge clk);
            chk("ustep_idle_led", {28'd0, bus.led_run}, 32'h1);
        end
        chk("ustep_cycle_cnt", bus.cycle_cnt, want_cnt());

        // Macro step until mpc_next returns to Main1.
        pulse_evt(2);
        chk("mstep_mode_led", {31'd0, bus.led_step_mode}, 32'd1);
        expect_ce(cyc + 1);
        expect_ce(cyc + 2);
        expect_ce(cyc + 3);
        pulse_evt(1);
        chk("mstep_led", {28'd0, bus.led_run}, 32'h4);
        bus.mpc_next = 9'h005;
        @(negedge clk);
        bus.mpc_next = 9'h006;
        @(negedge clk);
        bus.mpc_next = 9'h000;
        @(negedge clk);
        chk("mstep_done_led", {28'd0, bus.led_run}, 32'h1);

        // Macro step entered already at Main1 still issues one pulse.
        expect_ce(cyc + 1);
        pulse_evt(1);
        repeat (3) @(negedge clk);
        chk("mstep1_done_led", {28'd0, bus.led_run}, 32'h1);
        pulse_evt(2);
        chk("umode_led", {31'd0, bus.led_step_mode}, 32'd0);
        chk("mstep_cycle_cnt", bus.cycle_cnt, want_cnt());

        // Halt wins over a simultaneous stop; the in-flight pulse completes.
        expect_ce(cyc + 1);
        expect_ce(cyc + 2);
        pulse_evt(0);
        @(negedge clk);
        bus.core_halt      = 1'b1;
        bus.start_stop_evt = 1'b1;
        @(negedge clk);
        bus.core_halt      = 1'b0;
        bus.start_stop_evt = 1'b0;
        chk("halt_led", {28'd0, bus.led_run}, 32'h8);
        chk("halt_core_ce", {31'd0, bus.core_ce}, 32'd0);
        pulse_evt(1);
        pulse_evt(0);
        pulse_evt(2);
        repeat (3) @(negedge clk);
        chk("halt_stays_led", {28'd0, bus.led_run}, 32'h8);
        chk("halt_mode_ignored", {31'd0, bus.led_step_mode}, 32'd0);
        chk("halt_cycle_cnt", bus.cycle_cnt, want_cnt());
        do_reset();
        chk("halt_exit_led", {28'd0, bus.led_run}, 32'h1);

        // Reset during RUN drops core_ce without waiting for a clock edge.
        for (int k = 1; k <= 3; k++) expect_ce(cyc + k);
        pulse_evt(0);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_core_ce", {31'd0, bus.core_ce}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b0;
        exp_total = 0;
        @(negedge clk);
        chk("post_rst_led", {28'd0, bus.led_run}, 32'h1);
        chk("post_rst_cycle_cnt", bus.cycle_cnt, 32'd0);

        repeat (4) @(negedge clk);
        chk("pending_pulses", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
